// File: rtl/gamma_lut_banked_if.sv
// Pixel, table-write and commit signals of the banked gamma LUT.
// Master drives pixels, table writes and commits; slave returns mapped pixels and bank status.
interface gamma_lut_banked_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 3,
   parameter int CHAN_BITS  = 2
);
   logic                           enable;
   logic                           in_vld;
   logic [CHANNELS*DATA_WIDTH-1:0] in_dat;
   logic                           frame_start;
   logic                           out_vld;
   logic [CHANNELS*DATA_WIDTH-1:0] out_dat;
   logic                           wr_en;
   logic [CHAN_BITS-1:0]           wr_chan;
   logic [DATA_WIDTH-1:0]          wr_addr;
   logic [DATA_WIDTH-1:0]          wr_dat;
   logic                           commit;
   logic                           commit_pending;
   logic                           active_bank;

   modport master (
      output enable, in_vld, in_dat, frame_start, wr_en, wr_chan, wr_addr, wr_dat, commit,
      input  out_vld, out_dat, commit_pending, active_bank
   );

   modport slave (
      input  enable, in_vld, in_dat, frame_start, wr_en, wr_chan, wr_addr, wr_dat, commit,
      output out_vld, out_dat, commit_pending, active_bank
   );
endinterface

// File: rtl/gamma_lut_banked.sv
// Per-channel double-buffered gamma LUT, banks swapped on frame_start after a commit; 2-cycle latency.
// No backpressure: accepts one pixel per clock.
module gamma_lut_banked #(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 3,
   parameter int CHAN_BITS  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   gamma_lut_banked_if.slave io_px
);
   localparam int DEPTH = 1 << DATA_WIDTH;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t r_state;
   logic   r_active_bank;
   logic   w_swap;
   logic   w_next_bank;

   logic   r_s1_vld;
   logic   r_s1_en;
   logic   r_s1_bank;
   logic   r_out_vld;
   logic [CHANNELS*DATA_WIDTH-1:0] w_out_dat;

   // A commit arriving together with frame_start swaps at once and never shows as pending.
   assign w_swap      = io_px.frame_start && ((r_state == ST_PENDING) || io_px.commit);
   assign w_next_bank = r_active_bank ^ w_swap;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_active_bank <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_swap) begin
                  r_active_bank <= w_next_bank;
               end else if (io_px.commit) begin
                  r_state <= ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (w_swap) begin
                  r_active_bank <= w_next_bank;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1_vld  <= 1'b0;
         r_out_vld <= 1'b0;
      end else begin
         r_s1_vld  <= io_px.in_vld;
         r_out_vld <= r_s1_vld;
      end
   end

   // The bank is latched with the pixel so a later swap cannot retarget it.
   always_ff @(posedge i_clk) begin
      r_s1_en   <= io_px.enable;
      r_s1_bank <= w_next_bank;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];
      logic [DATA_WIDTH-1:0] r_s1_dat;
      logic [DATA_WIDTH-1:0] r_out_dat;
      logic                  w_wr_hit;

      assign w_wr_hit = io_px.wr_en && (io_px.wr_chan == CHAN_BITS'(c));

      always_ff @(posedge i_clk) begin
         if (w_wr_hit) begin
            r_mem[{~r_active_bank, io_px.wr_addr}] <= io_px.wr_dat;
         end
      end

      always_ff @(posedge i_clk) begin
         r_s1_dat <= io_px.in_dat[c*DATA_WIDTH +: DATA_WIDTH];
      end

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_out_dat <= '0;
         end else if (r_s1_vld) begin
            r_out_dat <= r_s1_en ? r_mem[{r_s1_bank, r_s1_dat}] : r_s1_dat;
         end
      end

      assign w_out_dat[c*DATA_WIDTH +: DATA_WIDTH] = r_out_dat;
   end

   assign io_px.out_vld        = r_out_vld;
   assign io_px.out_dat        = w_out_dat;
   assign io_px.commit_pending = (r_state == ST_PENDING);
   assign io_px.active_bank    = r_active_bank;
endmodule

// File: tb/tb_gamma_lut_banked.sv
// Randomised bench for gamma_lut_banked with a table/bank reference model and literal spot checks.
module tb_gamma_lut_banked;
   localparam int DW = 8;
   localparam int CH = 3;
   localparam int CB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gamma_lut_banked_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .CHAN_BITS(CB)) px();

   gamma_lut_banked #(.DATA_WIDTH(DW), .CHANNELS(CH), .CHAN_BITS(CB)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_px   (px)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: tables, bank state and a two-slot output delay line.
   logic [DW-1:0]    tbl [CH][2][256];
   logic             m_bank, m_pend, m_d1_vld, m_out_vld;
   logic [CH*DW-1:0] m_d1_dat, m_out_dat;

   function automatic logic [CH*DW-1:0] lut(input logic b, input logic [CH*DW-1:0] d);
      logic [CH*DW-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++) r[c*DW +: DW] = tbl[c][b][d[c*DW +: DW]];
      return r;
   endfunction

   always begin : model_cmp
      logic s_rst_n, s_fs, s_cm, s_en, s_iv, s_we, s_swap, s_nb;
      logic [CB-1:0] s_wc;
      logic [DW-1:0] s_wa, s_wd;
      logic [CH*DW-1:0] s_id;
      @(posedge clk);
      s_rst_n = rst_n;        s_fs = px.frame_start; s_cm = px.commit;
      s_en    = px.enable;    s_iv = px.in_vld;      s_id = px.in_dat;
      s_we    = px.wr_en;     s_wc = px.wr_chan;     s_wa = px.wr_addr; s_wd = px.wr_dat;
      #1;
      if (!s_rst_n) begin
         m_bank = 1'b0; m_pend = 1'b0; m_d1_vld = 1'b0; m_out_vld = 1'b0; m_out_dat = '0;
      end else begin
         // A swap needs a frame boundary and either an earlier or a simultaneous commit.
         s_swap = s_fs && (m_pend || s_cm);
         s_nb   = s_swap ? ~m_bank : m_bank;
         m_out_vld = m_d1_vld;
         if (m_d1_vld) m_out_dat = m_d1_dat;
         m_d1_vld = s_iv;
         if (s_iv) m_d1_dat = s_en ? lut(s_nb, s_id) : s_id;
         if (s_we && (int'(s_wc) < CH)) tbl[s_wc][~m_bank][s_wa] = s_wd;
         m_pend = s_swap ? 1'b0 : (m_pend || s_cm);
         m_bank = s_nb;
      end
      chk("cyc_out_vld", px.out_vld, m_out_vld);
      chk("cyc_out_dat", px.out_dat, m_out_dat);
      chk("cyc_pending", px.commit_pending, m_pend);
      chk("cyc_bank",    px.active_bank, m_bank);
   end

   task automatic idle();
      px.in_vld = 1'b0; px.frame_start = 1'b0; px.commit = 1'b0; px.wr_en = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_wr(input int c, input int a, input logic [DW-1:0] v);
      px.wr_en = 1'b1; px.wr_chan = CB'(c); px.wr_addr = DW'(a); px.wr_dat = v;
      tick();
      px.wr_en = 1'b0;
   endtask

   task automatic rand_cycle(input bit allow_ctl);
      px.in_vld      = ($urandom_range(0, 3) != 0);
      px.in_dat      = (CH*DW)'($urandom);
      px.enable      = ($urandom_range(0, 4) != 0);
      px.frame_start = allow_ctl && ($urandom_range(0, 15) == 0);
      px.commit      = allow_ctl && ($urandom_range(0, 9) == 0);
      px.wr_en       = !px.frame_start && ($urandom_range(0, 1) == 1);
      px.wr_chan     = CB'($urandom_range(0, 3));
      px.wr_addr     = DW'($urandom);
      px.wr_dat      = DW'($urandom);
      tick();
   endtask

   initial begin
      px.enable = 1'b0; px.in_vld = 1'b0; px.in_dat = '0; px.frame_start = 1'b0;
      px.wr_en = 1'b0; px.wr_chan = '0; px.wr_addr = '0; px.wr_dat = '0; px.commit = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_out_vld", px.out_vld, 0);
      chk("rst_out_dat", px.out_dat, 0);
      chk("rst_pending", px.commit_pending, 0);
      chk("rst_bank",    px.active_bank, 0);
      rst_n = 1'b1;
      tick();

      // Shadow bank 1: ch0 identity, ch1 inverted, ch2 constant.
      for (int i = 0; i < 256; i++) begin
         drive_wr(0, i, DW'(i));
         drive_wr(1, i, DW'(255 - i));
         drive_wr(2, i, 8'h40);
      end

      px.commit = 1'b1;
      tick();
      px.commit = 1'b0; px.frame_start = 1'b1; px.in_vld = 1'b1; px.enable = 1'b1;
      px.in_dat = 24'h102030;
      tick();
      chk("t1_bank", px.active_bank, 1);
      idle();
      tick();
      chk("t1_out_vld", px.out_vld, 1);
      chk("t1_out_dat", px.out_dat, 24'h40DF30);

      for (int i = 0; i < 256; i++)
         for (int c = 0; c < CH; c++) drive_wr(c, i, DW'($urandom));

      // Long pending commit without a frame boundary.
      px.commit = 1'b1;
      tick();
      px.commit = 1'b0;
      for (int i = 0; i < 100; i++) rand_cycle(1'b0);
      idle();
      chk("t2_pending", px.commit_pending, 1);
      chk("t2_bank",    px.active_bank, 1);
      px.frame_start = 1'b1;
      tick();
      idle();
      chk("t2_swap_bank",    px.active_bank, 0);
      chk("t2_swap_pending", px.commit_pending, 0);

      // Commit and frame_start together, pixel in the same slot.
      px.commit = 1'b1; px.frame_start = 1'b1; px.in_vld = 1'b1; px.enable = 1'b1;
      px.in_dat = 24'h5AA511;
      tick();
      idle();
      chk("t3_bank",    px.active_bank, 1);
      chk("t3_pending", px.commit_pending, 0);
      tick();
      chk("t3_out_dat", px.out_dat, 24'h405A11);

      // Bypass with a 1,0,1 bubble pattern.
      px.enable = 1'b0; px.in_vld = 1'b1; px.in_dat = 24'hABCDEF;
      tick();
      px.in_vld = 1'b0; px.in_dat = 24'h123456;
      tick();
      px.in_vld = 1'b1; px.in_dat = 24'h654321;
      chk("t4_out_a",   px.out_dat, 24'hABCDEF);
      chk("t4_vld_a",   px.out_vld, 1);
      tick();
      idle();
      chk("t4_vld_gap", px.out_vld, 0);
      chk("t4_hold",    px.out_dat, 24'hABCDEF);
      tick();
      chk("t4_vld_c",   px.out_vld, 1);
      chk("t4_out_c",   px.out_dat, 24'h654321);

      // Ignored channel, then a shadow write that only shows after a swap.
      drive_wr(3, 8'h11, 8'h77);
      drive_wr(0, 8'h11, 8'h99);
      px.in_vld = 1'b1; px.enable = 1'b1; px.in_dat = 24'h000011;
      tick();
      idle();
      tick();
      chk("t5_shadow_hidden", px.out_dat[7:0], 8'h11);
      px.commit = 1'b1; px.frame_start = 1'b1; px.in_vld = 1'b1; px.enable = 1'b1;
      px.in_dat = 24'h000011;
      tick();
      idle();
      tick();
      chk("t5_shadow_live", px.out_dat[7:0], 8'h99);

      for (int i = 0; i < 2000; i++) rand_cycle(1'b1);
      idle();
      tick();

      // Reset with a pending commit and pixels in flight.
      px.commit = 1'b1;
      tick();
      px.commit = 1'b0; px.in_vld = 1'b1; px.enable = 1'b1; px.in_dat = (CH*DW)'($urandom);
      chk("t6_pending_before", px.commit_pending, 1);
      tick();
      rst_n = 1'b0; px.in_dat = (CH*DW)'($urandom);
      tick();
      chk("t6_rst_out_vld", px.out_vld, 0);
      chk("t6_rst_pending", px.commit_pending, 0);
      chk("t6_rst_bank",    px.active_bank, 0);
      chk("t6_rst_out_dat", px.out_dat, 0);
      rst_n = 1'b1;
      idle();
      tick();
      for (int i = 0; i < 300; i++) rand_cycle(1'b0);
      idle();
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/gamma_lut_banked.md
# gamma_lut_banked

Parametrised, multi-channel gamma/colour lookup stage with runtime-writable, double-buffered tables. It replaces fixed gamma curves with per-channel RAM tables that firmware loads through a write port; a commit request swaps the loaded (shadow) bank into service on the next frame boundary. This prevents tearing while tables are being rewritten. It sits in the preprocessing pipeline between the pixel source and the HDMI output formatter.

## Interface
- DATA_WIDTH, 8, bits per colour component; each table holds 2^DATA_WIDTH entries
- CHANNELS, 3, number of independent colour channels
- CHAN_BITS, 2, width of the channel select; must satisfy 2^CHAN_BITS >= CHANNELS

- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  1 = table lookup, 0 = bypass
- in_valid  in  1  input pixel qualifier
- in_data  in  CHANNELS*DATA_WIDTH  pixel; channel n occupies bits [n*DATA_WIDTH +: DATA_WIDTH]
- frame_start  in  1  single-cycle pulse marking the first pixel slot of a frame
- out_valid  out  1  output pixel qualifier
- out_data  out  CHANNELS*DATA_WIDTH  mapped pixel, same packing as in_data
- wr_en  in  1  table write strobe
- wr_chan  in  CHAN_BITS  channel whose table is written
- wr_addr  in  DATA_WIDTH  table index
- wr_data  in  DATA_WIDTH  table entry
- commit  in  1  single-cycle request to swap banks at the next frame_start
- commit_pending  out  1  commit accepted, swap not yet performed
- active_bank  out  1  bank currently used for lookups

## Operation
- Storage: per channel, two banks of 2^DATA_WIDTH x DATA_WIDTH. Table contents are not reset and are undefined until written.
- Writes: when wr_en=1 and wr_chan < CHANNELS, write wr_data to table[wr_chan][~active_bank][wr_addr]. Writes with wr_chan >= CHANNELS are ignored. Writes never target the active bank.
- Commit state machine, two states:
  - IDLE (commit_pending=0): commit=1 moves to PENDING.
  - PENDING (commit_pending=1): frame_start=1 toggles active_bank and returns to IDLE. Further commits while PENDING have no effect.
  - commit and frame_start in the same cycle while in IDLE: the commit is accepted and the swap happens on that same frame_start. commit_pending stays 0.
  - frame_start with no pending commit: no change.
- Lookup bank: the bank used for a pixel is the value active_bank takes after this cycle's swap decision. A pixel sampled together with the swapping frame_start uses the new bank.
- Writes while PENDING go to the shadow bank, which is the bank about to become active. After the swap, writes target the new shadow bank (the previously active one).
- Bypass: when enable=0, out_data equals in_data delayed. enable is sampled per pixel at stage 1.
- in_valid=0 pixels propagate as bubbles. out_data holds its last value when out_valid=0.

## Timing
- Fixed latency of 2 cycles from in_valid/in_data to out_valid/out_data, in both lookup and bypass mode.
  - Stage 1 registers the pixel, enable, valid and selected bank.
  - Stage 2 registers the synchronous RAM read, or the delayed pixel in bypass.
- Bank selection is captured at stage 1. A swap occurring while a pixel is in flight does not affect that pixel.
- Read during write: a read and a write to the same bank and address in the same cycle returns the old entry.
- Reset (reset=0 at a clock edge): out_valid=0, out_data=0, commit_pending=0, active_bank=0, pipeline valids cleared. Reset mid-frame discards in-flight pixels and any pending commit. Table contents are retained.
- Throughput: one pixel per clock, no backpressure.

## Test plan
- Write bank1 ch0 with identity, ch1 with inverted (255-i), ch2 with constant 0x40. Commit, then pulse frame_start with in_data={0x10,0x20,0x30} (ch2,ch1,ch0). Expect active_bank=1 and, 2 cycles later, out_data={0x40,0xDF,0x30}.
- Commit with no frame_start for 100 cycles: commit_pending=1 throughout, active_bank unchanged, outputs still use the old bank. Next frame_start: swap occurs and commit_pending=0.
- Commit and frame_start in the same cycle: active_bank toggles at that edge, commit_pending never asserts, and the pixel in that cycle uses the new bank.
- Bypass: enable=0 with in_data=0xABCDEF and in_valid=1 -> out_data=0xABCDEF exactly 2 cycles later. A bubble pattern of 1,0,1 on in_valid appears unchanged on out_valid.
- Write with wr_chan=3 (CHANNELS=3): no table changes. A write to the shadow bank at the active-bank address produces no change in output until commit plus frame_start.
- Assert reset while commit_pending=1 with pixels in flight: next cycle out_valid=0, commit_pending=0, active_bank=0. Previously loaded bank-0 contents are still returned after reset.
